ball_axis_motion: RTL and testbench
===================================

# ball_axis_motion

Parametrised ball motion unit for one screen axis. It replaces the per-frame counter-slip scheme with an explicit position register. Per frame, the position is stepped by a programmable speed, with wall detection, optional automatic bounce, paddle-reflect requests, serve/recentre, and video generation against a scan counter. One instance drives the horizontal component and a second instance drives the vertical component of the ball's video signal. Both sit between the VGA timing generator and the video mixer.

## Interface
- p_EXTENT, 640: visible pixels (or lines) along the axis.
- p_SIZE, 8: ball size along the axis, in pixels; 1 ≤ p_SIZE < p_EXTENT.
- p_SPEED_BITS, 3: width of i_Speed.
- p_BOUNCE, 1: 1 = reflect at walls; 0 = stop at the wall and halt.
- p_INIT_DIR, 1: direction after reset (1 = increasing, 0 = decreasing).
- Derived constants: W = $clog2(p_EXTENT+1); POS_MAX = p_EXTENT − p_SIZE; CENTER = (p_EXTENT − p_SIZE)/2.

Ports:
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Frame  in  1  one-cycle pulse, once per frame (start of vertical blank); triggers motion.
- i_Speed  in  p_SPEED_BITS  steps per frame; sampled only on an accepted i_Frame.
- i_Reflect  in  1  paddle-hit pulse; requests a direction flip at the next accepted frame.
- i_Serve  in  1  pulse: recentre, clear halt, load direction.
- i_Serve_Dir  in  1  direction loaded by i_Serve.
- i_Scan_Rst  in  1  synchronous clear of the scan counter (line start for the H axis, frame start for the V axis).
- i_Scan_En  in  1  advances the scan counter (active pixel for the H axis, active line for the V axis).
- o_Video  out  1  high while the scan counter is inside the ball.
- o_Pos  out  W  current ball position (leading edge).
- o_Dir  out  1  current direction.
- o_Hit  out  1  one-cycle pulse when a wall is hit.
- o_Hit_Hi  out  1  qualifies o_Hit: 1 = POS_MAX wall, 0 = wall at 0.
- o_Halted  out  1  high in state HALT.
- o_Overrun  out  1  one-cycle pulse when i_Frame arrives while not in IDLE.

## Operation
- States: IDLE, MOVE, HALT.
- Reset values: state IDLE, pos CENTER, dir p_INIT_DIR, steps 0, reflect-pending 0, scan counter 0, o_Hit/o_Hit_Hi/o_Overrun/o_Halted 0.
- i_Serve has highest priority, in any state:
  - pos ← CENTER, dir ← i_Serve_Dir, pending ← 0, steps ← 0, state ← IDLE.
  - i_Frame and i_Reflect in the same cycle are discarded.
- i_Reflect sets pending in any state. It is never applied mid-frame.
- IDLE + i_Frame:
  - If pending is set, dir flips and pending clears.
  - If i_Speed = 0, stay in IDLE.
  - Otherwise steps ← i_Speed and state → MOVE.
  - The flip and the speed load happen in the same edge.
- MOVE: exactly one step per cycle.
  - Wall condition: (dir=1 and pos=POS_MAX) or (dir=0 and pos=0).
  - Wall reached, p_BOUNCE=1: pos unchanged, dir flips, o_Hit pulses, step consumed.
  - Wall reached, p_BOUNCE=0: pos unchanged, o_Hit pulses, state → HALT, remaining steps discarded.
  - Wall not reached: pos ± 1, step consumed.
  - When the last step is consumed, state → IDLE.
- HALT: position frozen, o_Halted=1. i_Frame is ignored and does not raise o_Overrun. Only i_Serve exits HALT.
- i_Frame in MOVE: ignored; o_Overrun pulses.
- Scan counter (W bits):
  - i_Scan_Rst → 0, with priority over i_Scan_En.
  - Otherwise i_Scan_En increments it, saturating at 2^W−1.
- o_Video = (cnt ≥ pos) && (cnt < pos + p_SIZE).
  - Computed combinationally from registers.
  - Compare at W+1 bits so that pos + p_SIZE cannot wrap.
- pos never leaves [0, POS_MAX]; the bounds are inclusive.

## Timing
- i_Frame accepted at edge t with speed S > 0: MOVE during cycles t+1 … t+S; final pos visible after edge t+S; IDLE from t+S.
- Motion budget: S ≤ 2^p_SPEED_BITS − 1 cycles. This is far shorter than vertical blank, so motion never overlaps the active scan.
- o_Hit and o_Hit_Hi assert in the cycle after the edge that detected the wall, for one cycle.
- A bounce in the final step leaves pos at the wall with dir already flipped.
- o_Overrun asserts for one cycle after the offending edge.
- Asynchronous reset mid-MOVE immediately forces all reset values. No partial step completes.
- o_Video has zero latency relative to the scan counter register, i.e. one cycle after the i_Scan_En edge.

## Test plan
1. Reset, then i_Frame with i_Speed=3, dir=1 (p_EXTENT=640, p_SIZE=8) → pos 316→319 over 3 cycles; back in IDLE at the 4th edge; o_Hit never asserts.
2. Serve with dir=1, pos driven near the wall, then one frame at speed 5 with the ball 2 steps from POS_MAX=632 → pos reaches 632; o_Hit=1 with o_Hit_Hi=1 for one cycle; dir=0; final pos 630 (p_BOUNCE=1). Repeat with p_BOUNCE=0 → pos 632, o_Halted=1; later frames do not move the ball; i_Serve → pos 316, o_Halted=0.
3. i_Reflect pulsed mid-frame with dir=1, then i_Frame with speed 2 → dir=0 from the frame edge; pos 316→314; pending cleared, so the next frame continues with dir=0.
4. i_Frame during MOVE → o_Overrun single pulse; step count and final pos unaffected.
5. i_Serve together with i_Frame and i_Reflect in one cycle → pos 316, dir=i_Serve_Dir, no MOVE, pending 0.
6. Scan check with pos=316: pulse i_Scan_Rst, then 640 cycles of i_Scan_En → o_Video high exactly while cnt ∈ [316, 323]. Repeat at pos=0 and pos=632 to cover the boundary pixels.

Source files
------------

// File: rtl/ball_axis_motion.sv
// Ball motion along one screen axis: per-frame stepping with wall handling,
// paddle-reflect requests, serve/recentre and ball video against a scan counter.
module ball_axis_motion #(
  parameter int p_EXTENT     = 640,
  parameter int p_SIZE       = 8,
  parameter int p_SPEED_BITS = 3,
  parameter bit p_BOUNCE     = 1'b1,
  parameter bit p_INIT_DIR   = 1'b1,
  localparam int W           = $clog2(p_EXTENT + 1)
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset_n,
  input  logic                    i_Frame,
  input  logic [p_SPEED_BITS-1:0] i_Speed,
  input  logic                    i_Reflect,
  input  logic                    i_Serve,
  input  logic                    i_Serve_Dir,
  input  logic                    i_Scan_Rst,
  input  logic                    i_Scan_En,
  output logic                    o_Video,
  output logic [W-1:0]            o_Pos,
  output logic                    o_Dir,
  output logic                    o_Hit,
  output logic                    o_Hit_Hi,
  output logic                    o_Halted,
  output logic                    o_Overrun
);

  localparam logic [W-1:0] POS_MAX = W'(p_EXTENT - p_SIZE);
  localparam logic [W-1:0] CENTER  = W'((p_EXTENT - p_SIZE) / 2);
  localparam logic [W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, MOVE, HALT} state_t;

  state_t                  state_q, state_d;
  logic [W-1:0]            pos_q, pos_d;
  logic                    dir_q, dir_d;
  logic [p_SPEED_BITS-1:0] steps_q, steps_d;
  logic                    pend_q, pend_d;
  logic [W-1:0]            cnt_q, cnt_d;
  logic                    hit_q, hit_d;
  logic                    hit_hi_q, hit_hi_d;
  logic                    ovr_q, ovr_d;
  logic                    wall;

  assign wall = dir_q ? (pos_q == POS_MAX) : (pos_q == '0);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    steps_d  = steps_q;
    pend_d   = pend_q | i_Reflect;
    hit_d    = 1'b0;
    hit_hi_d = 1'b0;
    ovr_d    = 1'b0;
    if (i_Serve) begin
      // Serve wins outright; coincident frame/reflect pulses are dropped.
      state_d = IDLE;
      pos_d   = CENTER;
      dir_d   = i_Serve_Dir;
      pend_d  = 1'b0;
      steps_d = '0;
    end else begin
      unique case (state_q)
        IDLE: if (i_Frame) begin
          if (pend_q) begin
            dir_d  = ~dir_q;
            pend_d = i_Reflect;
          end
          if (i_Speed != '0) begin
            steps_d = i_Speed;
            state_d = MOVE;
          end
        end
        MOVE: begin
          ovr_d = i_Frame;
          if (wall) begin
            hit_d    = 1'b1;
            hit_hi_d = dir_q;
            if (p_BOUNCE) begin
              dir_d   = ~dir_q;
              steps_d = steps_q - p_SPEED_BITS'(1);
              if (steps_q == p_SPEED_BITS'(1)) state_d = IDLE;
            end else begin
              steps_d = '0;
              state_d = HALT;
            end
          end else begin
            pos_d   = dir_q ? pos_q + W'(1) : pos_q - W'(1);
            steps_d = steps_q - p_SPEED_BITS'(1);
            if (steps_q == p_SPEED_BITS'(1)) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_Scan_Rst)                      cnt_d = '0;
    else if (i_Scan_En && cnt_q != CNT_MAX) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      pos_q    <= CENTER;
      dir_q    <= p_INIT_DIR;
      steps_q  <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      hit_hi_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      steps_q  <= steps_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      hit_hi_q <= hit_hi_d;
      ovr_q    <= ovr_d;
    end
  end

  // One extra bit so pos + p_SIZE at the far wall cannot wrap.
  logic [W:0] cnt_x, pos_x, end_x;
  assign cnt_x = {1'b0, cnt_q};
  assign pos_x = {1'b0, pos_q};
  assign end_x = pos_x + (W+1)'(p_SIZE);

  assign o_Video   = (cnt_x >= pos_x) && (cnt_x < end_x);
  assign o_Pos     = pos_q;
  assign o_Dir     = dir_q;
  assign o_Hit     = hit_q;
  assign o_Hit_Hi  = hit_hi_q;
  assign o_Halted  = (state_q == HALT);
  assign o_Overrun = ovr_q;

endmodule

// File: tb/tb_ball_axis_motion.sv
// Directed bench: a bouncing (a_) and a halting (b_) instance share all inputs.
module tb_ball_axis_motion;
  localparam int W = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic frame = 1'b0, reflect = 1'b0, serve = 1'b0, serve_dir = 1'b0;
  logic scan_rst = 1'b0, scan_en = 1'b0;
  logic [2:0] speed = '0;

  logic a_video, a_dir, a_hit, a_hit_hi, a_halted, a_ovr;
  logic b_video, b_dir, b_hit, b_hit_hi, b_halted, b_ovr;
  logic [W-1:0] a_pos, b_pos;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ball_axis_motion #(.p_EXTENT(640), .p_SIZE(8), .p_SPEED_BITS(3), .p_BOUNCE(1'b1), .p_INIT_DIR(1'b1)) u_a (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Frame(frame), .i_Speed(speed), .i_Reflect(reflect),
    .i_Serve(serve), .i_Serve_Dir(serve_dir), .i_Scan_Rst(scan_rst), .i_Scan_En(scan_en),
    .o_Video(a_video), .o_Pos(a_pos), .o_Dir(a_dir), .o_Hit(a_hit), .o_Hit_Hi(a_hit_hi),
    .o_Halted(a_halted), .o_Overrun(a_ovr));

  ball_axis_motion #(.p_EXTENT(640), .p_SIZE(8), .p_SPEED_BITS(3), .p_BOUNCE(1'b0), .p_INIT_DIR(1'b1)) u_b (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Frame(frame), .i_Speed(speed), .i_Reflect(reflect),
    .i_Serve(serve), .i_Serve_Dir(serve_dir), .i_Scan_Rst(scan_rst), .i_Scan_En(scan_en),
    .o_Video(b_video), .o_Pos(b_pos), .o_Dir(b_dir), .o_Hit(b_hit), .o_Hit_Hi(b_hit_hi),
    .o_Halted(b_halted), .o_Overrun(b_ovr));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input int s);
    frame = 1'b1; speed = 3'(s);
    tick();
    frame = 1'b0;
    repeat (s) tick();
  endtask

  task automatic do_serve(input logic d);
    serve = 1'b1; serve_dir = d;
    tick();
    serve = 1'b0;
  endtask

  // Sweep the scan counter over the whole axis and compare both video outputs.
  task automatic scan(input string tag, input int pa, input int pb);
    scan_rst = 1'b1;
    tick();
    scan_rst = 1'b0; scan_en = 1'b1;
    for (int c = 0; c <= 640; c++) begin
      chk({tag, "_a_video"}, int'(a_video), int'(c >= pa && c < pa + 8));
      chk({tag, "_b_video"}, int'(b_video), int'(c >= pb && c < pb + 8));
      tick();
    end
    scan_en = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_pos", int'(a_pos), 316);
    chk("rst_dir", int'(a_dir), 1);
    chk("rst_hit", int'(a_hit), 0);
    chk("rst_hit_hi", int'(a_hit_hi), 0);
    chk("rst_halted", int'(b_halted), 0);
    chk("rst_ovr", int'(a_ovr), 0);
    chk("rst_video", int'(a_video), 0);
    rst_n = 1'b1;
    tick();

    // 1: speed 3 from centre
    frame = 1'b1; speed = 3'd3;
    tick();
    frame = 1'b0;
    chk("t1_pos_frame_edge", int'(a_pos), 316);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_pos_step", int'(a_pos), 316 + k);
      chk("t1_no_hit", int'(a_hit), 0);
    end
    tick();
    chk("t1_pos_idle", int'(a_pos), 319);
    frame = 1'b1; speed = 3'd1;
    tick();
    frame = 1'b0;
    chk("t1_idle_no_ovr", int'(a_ovr), 0);
    tick();
    chk("t1_pos_next", int'(a_pos), 320);

    // 3: reflect request applied at next frame edge
    do_serve(1'b1);
    chk("t3_serve_pos", int'(a_pos), 316);
    reflect = 1'b1;
    tick();
    reflect = 1'b0;
    tick();
    chk("t3_dir_held_midframe", int'(a_dir), 1);
    frame = 1'b1; speed = 3'd2;
    tick();
    frame = 1'b0;
    chk("t3_dir_flip", int'(a_dir), 0);
    repeat (2) tick();
    chk("t3_pos", int'(a_pos), 314);
    do_frame(2);
    chk("t3_pos_next", int'(a_pos), 312);
    chk("t3_dir_next", int'(a_dir), 0);

    // 4: overrun during MOVE
    do_serve(1'b1);
    frame = 1'b1; speed = 3'd5;
    tick();
    frame = 1'b0;
    repeat (2) tick();
    chk("t4_pos_mid", int'(a_pos), 318);
    frame = 1'b1; speed = 3'd7;
    tick();
    frame = 1'b0;
    chk("t4_ovr_pulse", int'(a_ovr), 1);
    chk("t4_pos_ovr", int'(a_pos), 319);
    tick();
    chk("t4_ovr_clear", int'(a_ovr), 0);
    repeat (2) tick();
    chk("t4_pos_final", int'(a_pos), 321);
    tick();
    chk("t4_pos_stopped", int'(a_pos), 321);

    // 5: serve with coincident frame and reflect
    serve = 1'b1; serve_dir = 1'b0; frame = 1'b1; reflect = 1'b1; speed = 3'd3;
    tick();
    serve = 1'b0; frame = 1'b0; reflect = 1'b0;
    chk("t5_pos", int'(a_pos), 316);
    chk("t5_dir", int'(a_dir), 0);
    repeat (3) tick();
    chk("t5_no_move", int'(a_pos), 316);
    do_frame(1);
    chk("t5_no_pending_dir", int'(a_dir), 0);
    chk("t5_pos_after", int'(a_pos), 315);

    // 2: walk to 630 then hit POS_MAX wall
    do_serve(1'b1);
    repeat (44) do_frame(7);
    do_frame(6);
    chk("t2_a_pre", int'(a_pos), 630);
    chk("t2_b_pre", int'(b_pos), 630);
    frame = 1'b1; speed = 3'd5;
    tick();
    frame = 1'b0;
    repeat (2) tick();
    chk("t2_a_wall", int'(a_pos), 632);
    chk("t2_a_no_hit_yet", int'(a_hit), 0);
    tick();
    chk("t2_a_hit", int'(a_hit), 1);
    chk("t2_a_hit_hi", int'(a_hit_hi), 1);
    chk("t2_a_dir", int'(a_dir), 0);
    chk("t2_a_pos_at_hit", int'(a_pos), 632);
    chk("t2_b_hit", int'(b_hit), 1);
    chk("t2_b_hit_hi", int'(b_hit_hi), 1);
    chk("t2_b_halted", int'(b_halted), 1);
    tick();
    chk("t2_a_hit_once", int'(a_hit), 0);
    chk("t2_a_pos_back", int'(a_pos), 631);
    tick();
    chk("t2_a_final", int'(a_pos), 630);
    chk("t2_b_pos", int'(b_pos), 632);
    frame = 1'b1; speed = 3'd3;
    tick();
    frame = 1'b0;
    chk("t2_b_halt_no_ovr", int'(b_ovr), 0);
    repeat (3) tick();
    chk("t2_b_frozen", int'(b_pos), 632);
    chk("t2_b_still_halted", int'(b_halted), 1);
    chk("t2_a_moved", int'(a_pos), 627);

    // 6: scan sweeps at far wall, centre and zero
    scan("t6_far", 627, 632);
    do_serve(1'b1);
    chk("t2_b_serve_pos", int'(b_pos), 316);
    chk("t2_b_serve_unhalt", int'(b_halted), 0);
    scan("t6_mid", 316, 316);
    do_serve(1'b0);
    repeat (45) do_frame(7);
    do_frame(1);
    chk("t6_a_zero", int'(a_pos), 0);
    chk("t6_b_zero", int'(b_pos), 0);
    scan("t6_zero", 0, 0);

    // low wall hit qualifier
    do_frame(1);
    chk("t6_low_hit_a", int'(a_hit), 1);
    chk("t6_low_hit_hi_a", int'(a_hit_hi), 0);
    chk("t6_low_pos_a", int'(a_pos), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
